// File: rtl/lane_rr_scheduler.sv
// lane_rr_scheduler: four one-entry lane buffers (in_valid/in_ready, in_data0..3 -> hold0..3) round-robin granted onto sel/out_valid, drained by out_ready
module lane_rr_scheduler #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        in_valid,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  input  logic [DATA_W-1:0] in_data3,
  output logic [3:0]        in_ready,
  output logic [DATA_W-1:0] hold0,
  output logic [DATA_W-1:0] hold1,
  output logic [DATA_W-1:0] hold2,
  output logic [DATA_W-1:0] hold3,
  output logic [1:0]        sel,
  output logic              out_valid,
  input  logic              out_ready
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state_q, state_d;
  logic [3:0] full_q, full_d, cap, drain, cand;
  logic [1:0] sel_q, sel_d, pick;
  logic arb;
  logic [DATA_W-1:0] din [4];
  logic [DATA_W-1:0] hold_q [4];
  assign din = '{in_data0, in_data1, in_data2, in_data3};
  assign cap = in_valid & ~full_q;
  assign drain = (state_q == GRANT && out_ready) ? 4'(1) << sel_q : 4'b0;
  assign full_d = (full_q | cap) & ~drain;
  assign cand = full_q & ~drain;
  assign arb = state_q == IDLE || out_ready;
  always_comb begin
    pick = sel_q;
    for (int k = 4; k >= 1; k--) if (cand[sel_q + 2'(k)]) pick = sel_q + 2'(k);
    state_d = arb ? (|cand ? GRANT : IDLE) : state_q;
    sel_d = arb && |cand ? pick : sel_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q <= 2'b11;
      full_q <= 4'b0;
      for (int i = 0; i < 4; i++) hold_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      full_q <= full_d;
      for (int i = 0; i < 4; i++) if (cap[i]) hold_q[i] <= din[i];
    end
  end
  assign in_ready = ~full_q;
  assign out_valid = state_q == GRANT;
  assign sel = sel_q;
  assign hold0 = hold_q[0];
  assign hold1 = hold_q[1];
  assign hold2 = hold_q[2];
  assign hold3 = hold_q[3];
endmodule

// File: tb/tb_lane_rr_scheduler.sv
// tb_lane_rr_scheduler: directed and randomized checks of lane_rr_scheduler against a rule-level model
module tb_lane_rr_scheduler;
  logic clk = 0;
  logic rst = 1;
  logic [3:0] in_valid = 0;
  logic [3:0] in_data0 = 0, in_data1 = 0, in_data2 = 0, in_data3 = 0;
  logic [3:0] in_ready, hold0, hold1, hold2, hold3;
  logic [1:0] sel;
  logic out_valid;
  logic out_ready = 0;
  int tests = 0, fails = 0;
  bit m_full [4];
  logic [3:0] m_hold [4];
  int m_sel = 3;
  bit m_ov = 0;

  lane_rr_scheduler #(.DATA_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
    .in_ready(in_ready), .hold0(hold0), .hold1(hold1), .hold2(hold2), .hold3(hold3),
    .sel(sel), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [3:0] v, input logic [15:0] d, input bit r, input bit rs);
    bit hs;
    int nsel;
    bit nov;
    if (rs) begin
      for (int i = 0; i < 4; i++) begin
        m_full[i] = 0;
        m_hold[i] = 0;
      end
      m_sel = 3;
      m_ov = 0;
      return;
    end
    hs = m_ov && r;
    nsel = m_sel;
    nov = m_ov;
    if (!m_ov || hs) begin
      nov = 0;
      for (int k = 4; k >= 1; k--) begin
        int l;
        l = (m_sel + k) % 4;
        if (m_full[l] && !(hs && l == m_sel)) begin
          nsel = l;
          nov = 1;
        end
      end
    end
    for (int i = 0; i < 4; i++)
      if (v[i] && !m_full[i]) begin
        m_hold[i] = d[4*i +: 4];
        m_full[i] = 1;
      end
    if (hs) m_full[m_sel] = 0;
    m_sel = nsel;
    m_ov = nov;
  endfunction

  task automatic drive(input logic [3:0] v, input logic [15:0] d, input bit r, input bit rs);
    in_valid = v;
    {in_data3, in_data2, in_data1, in_data0} = d;
    out_ready = r;
    rst = rs;
    @(posedge clk);
    model(v, d, r, rs);
    #1;
  endtask

  task automatic test_reset();
    drive(4'($urandom), 16'($urandom), 1'($urandom), 1);
    drive(4'($urandom), 16'($urandom), 1'($urandom), 1);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (sel !== 2'd3) begin fails++; $display("FAIL reset_sel got %0d want 3", sel); end
    tests++; if (in_ready !== 4'hF) begin fails++; $display("FAIL reset_in_ready got %h want f", in_ready); end
    tests++; if ({hold3, hold2, hold1, hold0} !== 16'h0) begin fails++; $display("FAIL reset_hold got %h want 0", {hold3, hold2, hold1, hold0}); end
  endtask

  task automatic test_single_lane();
    drive(4'b0100, 16'h0A00, 1, 0);
    tests++; if (in_ready !== 4'b1011 || out_valid !== 1'b0) begin fails++; $display("FAIL single_e0 in_ready=%b out_valid=%b want 1011/0", in_ready, out_valid); end
    drive(4'b0000, 16'h0, 1, 0);
    tests++; if (out_valid !== 1'b1 || sel !== 2'd2 || hold2 !== 4'hA) begin fails++; $display("FAIL single_e1 ov=%b sel=%0d hold2=%h want 1/2/a", out_valid, sel, hold2); end
    drive(4'b0000, 16'h0, 1, 0);
    tests++; if (in_ready !== 4'hF || out_valid !== 1'b0) begin fails++; $display("FAIL single_e2 in_ready=%b ov=%b want 1111/0", in_ready, out_valid); end
  endtask

  task automatic test_round_robin();
    drive(0, 0, 1, 1);
    drive(4'hF, 16'h4321, 1, 0);
    for (int g = 0; g < 4; g++) begin
      drive(0, 0, 1, 0);
      tests++; if (out_valid !== 1'b1 || sel !== 2'(g) || dut.hold_q[g] !== 4'(g + 1)) begin fails++; $display("FAIL rr_grant%0d ov=%b sel=%0d want 1/%0d", g, out_valid, sel, g); end
    end
    drive(0, 0, 1, 0);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rr_idle ov=%b want 0", out_valid); end
  endtask

  task automatic test_back_pressure();
    drive(0, 0, 0, 1);
    drive(4'b0010, 16'h0050, 0, 0);
    drive(4'b1001, 16'h7006, 0, 0);
    for (int c = 0; c < 5; c++) begin
      tests++; if (out_valid !== 1'b1 || sel !== 2'd1 || hold1 !== 4'h5) begin fails++; $display("FAIL bp_hold%0d ov=%b sel=%0d hold1=%h want 1/1/5", c, out_valid, sel, hold1); end
      drive(c == 0 ? 4'b1001 : 4'b0000, 16'hF00F, 0, 0);
    end
    tests++; if (in_ready !== 4'b0100) begin fails++; $display("FAIL bp_full in_ready=%b want 0100", in_ready); end
    drive(0, 0, 1, 0);
    tests++; if (out_valid !== 1'b1 || sel !== 2'd3 || hold3 !== 4'h7) begin fails++; $display("FAIL bp_next ov=%b sel=%0d hold3=%h want 1/3/7", out_valid, sel, hold3); end
    drive(0, 0, 1, 0);
    tests++; if (out_valid !== 1'b1 || sel !== 2'd0 || hold0 !== 4'h6) begin fails++; $display("FAIL bp_last ov=%b sel=%0d hold0=%h want 1/0/6", out_valid, sel, hold0); end
    drive(0, 0, 1, 0);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_idle ov=%b want 0", out_valid); end
  endtask

  task automatic test_refill_fairness();
    int prev = -1, grants = 0;
    drive(0, 0, 1, 1);
    for (int c = 0; c < 24; c++) begin
      if (out_valid === 1'b1) begin
        tests++; if (sel > 2'd1 || int'(sel) == prev) begin fails++; $display("FAIL refill_order sel=%0d prev=%0d", sel, prev); end
        prev = int'(sel);
        grants++;
      end
      drive({2'b00, in_ready[1:0]}, 16'($urandom), 1, 0);
      tests++; if (out_valid !== m_ov || sel !== 2'(m_sel)) begin fails++; $display("FAIL refill_model ov=%b sel=%0d want %b/%0d", out_valid, sel, m_ov, m_sel); end
    end
    tests++; if (grants < 12) begin fails++; $display("FAIL refill_rate got %0d grants want >=12", grants); end
  endtask

  task automatic test_mid_reset();
    drive(0, 0, 0, 1);
    drive(4'b0111, 16'h0987, 0, 0);
    drive(0, 0, 0, 0);
    tests++; if (out_valid !== 1'b1 || in_ready !== 4'b1000) begin fails++; $display("FAIL midrst_pre ov=%b in_ready=%b want 1/1000", out_valid, in_ready); end
    drive(4'hF, 16'($urandom), 1, 1);
    tests++; if (out_valid !== 1'b0 || sel !== 2'd3 || in_ready !== 4'hF) begin fails++; $display("FAIL midrst_post ov=%b sel=%0d in_ready=%b want 0/3/1111", out_valid, sel, in_ready); end
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 1, 0);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_stale%0d ov=%b want 0", c, out_valid); end
    end
  endtask

  task automatic test_random();
    logic [3:0] exp_rdy;
    for (int c = 0; c < 400; c++) begin
      drive(4'($urandom), 16'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
      for (int i = 0; i < 4; i++) exp_rdy[i] = !m_full[i];
      tests++;
      if (out_valid !== m_ov || sel !== 2'(m_sel) || in_ready !== exp_rdy ||
          {hold3, hold2, hold1, hold0} !== {m_hold[3], m_hold[2], m_hold[1], m_hold[0]}) begin
        fails++;
        $display("FAIL random_c%0d ov=%b sel=%0d rdy=%b hold=%h want %b/%0d/%b/%h", c, out_valid, sel, in_ready,
                 {hold3, hold2, hold1, hold0}, m_ov, m_sel, exp_rdy, {m_hold[3], m_hold[2], m_hold[1], m_hold[0]});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_round_robin();
    test_back_pressure();
    test_refill_fairness();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
